// File: rtl/adder_share_if.sv
// Request/response bundle for the shared nibble-serial adder.
// master = operand producer / result consumer, slave = adder_share_ctrl.
interface adder_share_if #(
  parameter int WIDTH = 16
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic             req_cin0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic             req_cin1;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;

  modport master (
    output req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_cin0, req_a1, req_b1, req_cin1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );
endinterface

// File: rtl/adder_share_ctrl.sv
// Two-requester round-robin front end for one SLICE-bit adder, sequencing
// WIDTH-bit additions one slice per cycle with a registered inter-slice carry.
//
// state | meaning
// IDLE  | waiting for a request; req_ready asserted for the granted requester
// CALC  | adding slice idx, carry held in the carry flop
// DONE  | result presented on rsp_*, waiting for rsp_ready
module adder_share_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic           clk,
  input  logic           rst,
  adder_share_if.slave   bus,
  output logic           busy
);
  localparam int NPASS = WIDTH / SLICE;
  localparam int IW    = (NPASS > 1) ? $clog2(NPASS) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic             rr_ptr;
  logic [WIDTH-1:0] op_a, op_b, res;
  logic             carry;
  logic             c_msb;
  logic             id;
  logic [IW-1:0]    idx;

  logic             grant;
  logic             any_req;
  logic             last;
  logic [1:0]       ready_c;
  logic [SLICE:0]   slice_sum;

  always_comb begin
    grant   = rr_ptr;
    any_req = |bus.req_valid;
    if (bus.req_valid == 2'b01) grant = 1'b0;
    else if (bus.req_valid == 2'b10) grant = 1'b1;
    last      = (idx == IW'(NPASS - 1));
    slice_sum = {1'b0, op_a[idx*SLICE +: SLICE]} + {1'b0, op_b[idx*SLICE +: SLICE]}
              + {{SLICE{1'b0}}, carry};
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 2'b00;
    case (state)
      IDLE: begin
        // ready is gated by rst so nothing looks accepted while held in reset
        if (any_req && !rst) begin
          ready_c[grant] = 1'b1;
          state_nxt      = CALC;
        end
      end
      CALC: if (last) state_nxt = DONE;
      DONE: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      c_msb  <= 1'b0;
      id     <= 1'b0;
      idx    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            op_a   <= grant ? bus.req_a1   : bus.req_a0;
            op_b   <= grant ? bus.req_b1   : bus.req_b0;
            carry  <= grant ? bus.req_cin1 : bus.req_cin0;
            id     <= grant;
            idx    <= '0;
            rr_ptr <= ~grant;
          end
        end
        CALC: begin
          res[idx*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
          carry                   <= slice_sum[SLICE];
          // carry into the MSB recovered from the MSB's own sum bit
          if (last) c_msb <= op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ slice_sum[SLICE-1];
          else      idx   <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_id    = id;
  assign bus.rsp_sum   = res;
  assign bus.rsp_cout  = carry;
  assign bus.rsp_ovf   = c_msb ^ carry;
  assign busy          = (state != IDLE);
endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Shares one 4-bit ripple-carry adder slice between two requesters to perform 16-bit additions.
- Each 16-bit add is sequenced nibble-serially over 4 cycles, with a registered carry between slices.
- Round-robin arbitration between the two requesters; valid/ready handshake on requests and on the single response port.
- Sits between operand producers (e.g. an ALU/address unit) and the shared adder datapath; replaces a full-width parallel adder where area is tight.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, adder slice width in bits; the number of passes is WIDTH/SLICE (4 at defaults).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; one-hot or zero.
- req_a0, req_b0  input  WIDTH  requester 0 operands.
- req_cin0  input  1  requester 0 carry-in.
- req_a1, req_b1  input  WIDTH  requester 1 operands.
- req_cin1  input  1  requester 1 carry-in.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester index that owns the result.
- rsp_sum  output  WIDTH  sum.
- rsp_cout  output  1  unsigned carry-out.
- rsp_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous and active-high.
- On rst, all registers clear immediately, including mid-operation. Any in-flight add is discarded and produces no response.
  - Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, busy=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - Grant selection: if only one req_valid bit is set, grant that requester. If both are set, grant requester rr_ptr.
  - req_ready[grant] is asserted combinationally in IDLE only; it is 0 in all other states.
  - On the clock edge where req_valid[g] && req_ready[g]:
    - Latch that requester's a, b and cin into op_a, op_b and the carry flop.
    - Latch id=g, set idx=0, and set rr_ptr = ~g.
    - Go to CALC.
  - With no valid requests, stay in IDLE.
- CALC (one slice per cycle, idx = 0 .. WIDTH/SLICE-1):
  - The slice adds op_a[idx*SLICE +: SLICE] + op_b[idx*SLICE +: SLICE] + carry.
  - The slice sum is written into res[idx*SLICE +: SLICE]; the carry flop takes the slice carry-out.
  - On the last slice (idx=3), also capture the carry into the MSB, for ovf.
  - Then go to DONE; otherwise idx increments.
  - Request inputs are ignored in CALC; operand changes after acceptance have no effect.
- DONE:
  - rsp_valid=1, with rsp_sum=res, rsp_cout=carry, rsp_ovf as defined, rsp_id=id.
  - All response outputs are held stable while rsp_ready=0.
  - On an edge with rsp_valid && rsp_ready, go to IDLE; rsp_valid falls on the next cycle.
  - Response outputs keep their last values after the handshake; only rsp_valid drops.
- Latency: accept edge at cycle T. CALC runs in cycles T+1..T+4. rsp_valid is first high in cycle T+5.
- Throughput: with rsp_ready tied high, one add per 6 cycles (IDLE, 4×CALC, DONE). There is no overlap between transactions.
- Fairness: under continuous contention, grants strictly alternate. rr_ptr updates only on an accept.
- Arithmetic: unsigned modulo 2^WIDTH; carry-out and overflow are reported separately, with no saturation.

Test Plan:
- Requester 0 sends a=0x1234, b=0x4321, cin=0 -> req_ready[0] high in the accept cycle, rsp_valid high 5 cycles later; rsp_sum=0x5555, cout=0, ovf=0, id=0.
- Requester 1 sends a=0xFFFF, b=0x0001, cin=0 -> rsp_sum=0x0000, cout=1, ovf=0, id=1. Then 0x7FFF + 0x0000 with cin=1 -> 0x8000, cout=0, ovf=1.
- Both requesters hold valid for 3 transactions after reset (r0: 0x0001+0x0001, r1: 0x00F0+0x000F) -> responses in id order 0, 1, 0 with sums 0x0002, 0x00FF, 0x0002.
- Nibble carry chain: 0x0FFF + 0x0001 with cin=1 -> 0x1001, cout=0; carry propagates across slices 0→1→2→3.
- Backpressure: hold rsp_ready=0 for 4 cycles in DONE -> rsp_valid and rsp_sum stay stable, busy=1, req_ready=0 throughout; the new request is accepted only after the response handshake.
- Assert rst during CALC (idx=2) -> busy, rsp_valid and req_ready go to 0 immediately with no response. After release, the next contested request goes to requester 0.
